// File: rtl/result_reader_if.sv
// Output word stream of the result reader.
// Carries the valid/ready handshake, packed data and last marker.
interface result_reader_if;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/result_reader.sv
// Drains result SRAM sets a, b, c row by row into a 32-bit stream.
// Each row is buffered once, then emitted as ARRAY_SIZE/2 words.
module result_reader #(
  parameter int ARRAY_SIZE        = 32,
  parameter int OUTPUT_DATA_WIDTH = 16
) (
  input  logic                                    clk,
  input  logic                                    srstn,
  input  logic                                    drain_start,
  input  logic [6:0]                              num_rows,
  output logic [5:0]                              sram_raddr_a,
  output logic [5:0]                              sram_raddr_b,
  output logic [5:0]                              sram_raddr_c,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_a,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_b,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_c,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic [31:0]                             m_data,
  output logic                                    m_last,
  output logic                                    drain_busy,
  output logic                                    drain_done
);

  localparam int RW    = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int WORDS = ARRAY_SIZE / 2;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LATCH,
    S_SEND,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      row_q, row_d;
  logic [6:0]      nrows_q, nrows_d;
  logic [1:0]      set_q, set_d;
  logic [WW-1:0]   word_q, word_d;
  logic [RW-1:0]   buf_q, buf_d;
  logic [RW-1:0]   rdata_sel;
  logic            last_word;
  logic            last_row;

  assign last_word = (word_q == WW'(WORDS - 1));
  assign last_row  = ({1'b0, row_q} == (nrows_q - 7'd1));

  always_comb begin
    rdata_sel = sram_rdata_c;
    unique case (set_q)
      2'd0:    rdata_sel = sram_rdata_a;
      2'd1:    rdata_sel = sram_rdata_b;
      default: rdata_sel = sram_rdata_c;
    endcase
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    nrows_d = nrows_q;
    set_d   = set_q;
    word_d  = word_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: begin
        row_d = '0;
        if (drain_start) begin
          nrows_d = (num_rows > 7'd64) ? 7'd64 : num_rows;
          set_d   = '0;
          word_d  = '0;
          state_d = (num_rows == 7'd0) ? S_DONE : S_RD;
        end
      end
      S_RD: state_d = S_LATCH;
      S_LATCH: begin
        buf_d   = rdata_sel;
        word_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (m_ready) begin
          if (!last_word) begin
            word_d = word_q + WW'(1);
          end else begin
            word_d = '0;
            if (!last_row) begin
              row_d   = row_q + 6'd1;
              state_d = S_RD;
            end else if (set_q != 2'd2) begin
              row_d   = '0;
              set_d   = set_q + 2'd1;
              state_d = S_RD;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        row_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      nrows_q <= '0;
      set_q   <= '0;
      word_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      nrows_q <= nrows_d;
      set_q   <= set_d;
      word_q  <= word_d;
      buf_q   <= buf_d;
    end
  end

  assign sram_raddr_a = row_q;
  assign sram_raddr_b = row_q;
  assign sram_raddr_c = row_q;

  // Data is gated so the bus reads zero outside SEND.
  assign m_valid    = (state_q == S_SEND);
  assign m_data     = m_valid ? buf_q[32*int'(word_q) +: 32] : 32'd0;
  assign m_last     = m_valid && (set_q == 2'd2) && last_row && last_word;
  assign drain_busy = (state_q != S_IDLE);
  assign drain_done = (state_q == S_DONE);

endmodule

// File: tb/tb_result_reader.sv
// Random-stimulus bench for result_reader against a queue-based model.
// SRAMs are modelled as arrays with one-cycle registered read data.
module tb_result_reader;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic         clk = 1'b0;
  logic         srstn = 1'b0;
  logic         drain_start = 1'b0;
  logic [6:0]   num_rows = '0;
  logic [5:0]   ra, rb, rc;
  logic [511:0] rd_a = '0, rd_b = '0, rd_c = '0;
  logic         drain_busy, drain_done;

  logic [511:0] mem_a [64];
  logic [511:0] mem_b [64];
  logic [511:0] mem_c [64];

  exp_t        exp_q[$];
  logic [31:0] got_q[$];
  int cyc = 0;
  int passed = 0;
  int total = 0;
  int pct = 100;
  int lim = 0;
  int last_pos = 0;
  int last_cnt = 0;
  int last_hs = 0;
  int max_addr = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d = '0;
  logic        prev_l = 1'b0;

  result_reader_if rif();

  result_reader dut (
    .clk          (clk),
    .srstn        (srstn),
    .drain_start  (drain_start),
    .num_rows     (num_rows),
    .sram_raddr_a (ra),
    .sram_raddr_b (rb),
    .sram_raddr_c (rc),
    .sram_rdata_a (rd_a),
    .sram_rdata_b (rd_b),
    .sram_rdata_c (rd_c),
    .m_valid      (rif.m_valid),
    .m_ready      (rif.m_ready),
    .m_data       (rif.m_data),
    .m_last       (rif.m_last),
    .drain_busy   (drain_busy),
    .drain_done   (drain_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_a <= mem_a[ra];
    rd_b <= mem_b[rb];
    rd_c <= mem_c[rc];
  end

  initial rif.m_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    rif.m_ready = ($urandom_range(0, 99) < pct);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  task automatic build(input int n);
    int m;
    logic [511:0] row;
    m = (n > 64) ? 64 : n;
    lim = m;
    exp_q.delete();
    got_q.delete();
    last_pos = 0;
    last_cnt = 0;
    max_addr = 0;
    for (int s = 0; s < 3; s++)
      for (int r = 0; r < m; r++) begin
        row = (s == 0) ? mem_a[r] : (s == 1) ? mem_b[r] : mem_c[r];
        for (int k = 0; k < 16; k++)
          exp_q.push_back('{row[32*k +: 32], (s == 2 && r == m-1 && k == 15)});
      end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 64; r++)
      for (int w = 0; w < 16; w++) begin
        mem_a[r][32*w +: 32] = $urandom;
        mem_b[r][32*w +: 32] = $urandom;
        mem_c[r][32*w +: 32] = $urandom;
      end
  endtask

  task automatic start(input int n);
    @(negedge clk);
    build(n);
    drain_start = 1'b1;
    num_rows = 7'(n);
    @(negedge clk);
    drain_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    int c = 0;
    while (!drain_done && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", drain_done, 1);
    dc = cyc;
  endtask

  always @(negedge clk) begin
    if (!srstn) begin
      prev_stall = 1'b0;
    end else begin
      if (drain_busy) begin
        chk("raddr_equal", (ra == rb) && (rb == rc), 1);
        chk("raddr_range", ra <= ((lim == 0) ? 0 : lim - 1), 1);
        if (int'(ra) > max_addr) max_addr = int'(ra);
      end
      if (prev_stall) begin
        chk("stall_stable",
            rif.m_valid && rif.m_data == prev_d && rif.m_last == prev_l, 1);
      end
      prev_stall = 1'b0;
      if (rif.m_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", rif.m_valid, 0);
        end else begin
          chk("m_data", rif.m_data, exp_q[0].d);
          chk("m_last", rif.m_last, exp_q[0].l);
          if (rif.m_ready) begin
            got_q.push_back(rif.m_data);
            last_hs = cyc;
            if (rif.m_last) begin
              last_cnt++;
              last_pos = got_q.size();
            end
            void'(exp_q.pop_front());
          end else begin
            prev_stall = 1'b1;
            prev_d = rif.m_data;
            prev_l = rif.m_last;
          end
        end
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, rif.m_valid, 0);
    chk({nm, "_last"}, rif.m_last, 0);
    chk({nm, "_busy"}, drain_busy, 0);
    chk({nm, "_done"}, drain_done, 0);
    chk({nm, "_data"}, rif.m_data, 0);
    chk({nm, "_raddr"}, {ra, rb, rc}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc;
    logic [31:0] w;
    for (int r = 0; r < 64; r++) begin
      mem_a[r] = '0;
      mem_b[r] = '0;
      mem_c[r] = '0;
    end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    srstn = 1'b1;

    // N=1, element e of a[0] holds value e
    for (int e = 0; e < 32; e++) mem_a[0][16*e +: 16] = 16'(e);
    pct = 100;
    start(1);
    chk("t1_busy_T", drain_busy, 1);
    chk("t1_valid_T", rif.m_valid, 0);
    @(negedge clk);
    chk("t1_valid_T1", rif.m_valid, 0);
    @(negedge clk);
    chk("t1_valid_T2", rif.m_valid, 1);
    wait_done(200, dc);
    chk("t1_words", got_q.size(), 48);
    w = (got_q.size() > 0) ? got_q[0] : 32'hDEADBEEF;
    chk("t1_word0", w, 32'h00010000);
    w = (got_q.size() > 15) ? got_q[15] : 32'hDEADBEEF;
    chk("t1_word15", w, 32'h001F001E);
    chk("t1_last_pos", last_pos, 48);
    chk("t1_done_lat", dc, last_hs + 1);
    @(negedge clk);
    chk("t1_done_once", drain_done, 0);
    chk("t1_idle", drain_busy, 0);

    // N=4 with 50% backpressure
    fill_rand();
    pct = 50;
    start(4);
    wait_done(2000, dc);
    chk("t2_words", got_q.size(), 192);
    chk("t2_model_empty", exp_q.size(), 0);
    chk("t2_last_pos", last_pos, 192);

    // N=64 full address range
    fill_rand();
    pct = 100;
    start(64);
    wait_done(5000, dc);
    chk("t3_words", got_q.size(), 3072);
    chk("t3_max_addr", max_addr, 63);
    chk("t3_last_cnt", last_cnt, 1);

    // num_rows above 64 clamps to 64
    fill_rand();
    pct = 90;
    start(127);
    wait_done(6000, dc);
    chk("t4_words", got_q.size(), 3072);
    chk("t4_model_empty", exp_q.size(), 0);

    // num_rows = 0
    @(negedge clk);
    start(0);
    chk("t5_done_T1", drain_done, 1);
    chk("t5_busy_T1", drain_busy, 1);
    @(negedge clk);
    chk("t5_done_off", drain_done, 0);
    chk("t5_busy_off", drain_busy, 0);
    chk("t5_words", got_q.size(), 0);

    // drain_start pulsed during SEND
    fill_rand();
    pct = 70;
    start(3);
    for (int c = 0; c < 20 && !rif.m_valid; c++) @(negedge clk);
    chk("t6_in_send", rif.m_valid, 1);
    drain_start = 1'b1;
    num_rows = 7'd5;
    @(negedge clk);
    drain_start = 1'b0;
    wait_done(2000, dc);
    chk("t6_words", got_q.size(), 144);
    chk("t6_model_empty", exp_q.size(), 0);

    // async reset mid-row, then fresh N=2 drain
    fill_rand();
    pct = 100;
    start(4);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2;
    srstn = 1'b0;
    #1;
    chk_zero("t7_rst");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    srstn = 1'b1;
    pct = 60;
    start(2);
    wait_done(2000, dc);
    chk("t7_words", got_q.size(), 96);
    chk("t7_model_empty", exp_q.size(), 0);
    chk("t7_last_pos", last_pos, 96);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
